// File: rtl/key_scan_encoder.sv
// Six-button scanner: two-flop synchroniser, tick-enabled debounce FSM and
// single-owner key encoder with press pulse and long-press flag.
module key_scan_encoder #(
  parameter int CLK_DIV     = 50000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int NUM_KEYS    = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic                key_vaild,
  output logic [3:0]          key_code,
  output logic                key_press,
  output logic                key_long
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DB_W   = $clog2(DEBOUNCE_MS + 1);
  localparam int HOLD_W = $clog2(LONG_MS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_MS - 1);
  localparam logic [DB_W-1:0]   DB_ONE   = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_MS);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_MS - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, RELEASE_DB} state_t;

  logic [NUM_KEYS-1:0] sync_a, sync_b, pressed;
  logic [DIV_W-1:0]    div_cnt;
  logic                tick;
  state_t              state;
  logic [3:0]          cand;
  logic [DB_W-1:0]     db_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                any_pressed, cand_pressed;
  logic [3:0]          lowest;

  // Released level is all-ones, so reset preloads the synchroniser with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= '1;
      sync_b <= '1;
    end else begin
      sync_a <= key_in;
      sync_b <= sync_a;
    end
  end

  assign pressed = ~sync_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_ONE;
  end

  assign tick = (div_cnt == DIV_LAST);

  always_comb begin
    any_pressed  = |pressed;
    lowest       = 4'hF;
    cand_pressed = 1'b0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pressed[i]) lowest = 4'(i);
    end
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (cand == 4'(i)) cand_pressed = pressed[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cand      <= 4'h0;
      db_cnt    <= '0;
      hold_cnt  <= '0;
      key_vaild <= 1'b0;
      key_code  <= 4'hF;
      key_press <= 1'b0;
      key_long  <= 1'b0;
    end else begin
      key_press <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (any_pressed) begin
              cand   <= lowest;
              db_cnt <= DB_ONE;
              state  <= PRESS_DB;
            end
          end
          PRESS_DB: begin
            if (cand_pressed) begin
              if (db_cnt == DB_LAST) begin
                state     <= PRESSED;
                key_code  <= cand;
                key_vaild <= 1'b1;
                key_press <= 1'b1;
                hold_cnt  <= '0;
                db_cnt    <= '0;
              end else begin
                db_cnt <= db_cnt + DB_ONE;
              end
            end else begin
              state  <= IDLE;
              db_cnt <= '0;
            end
          end
          PRESSED: begin
            if (cand_pressed) begin
              if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + HOLD_ONE;
                if (hold_cnt == HOLD_PRE) key_long <= 1'b1;
              end
            end else begin
              db_cnt <= DB_ONE;
              state  <= RELEASE_DB;
            end
          end
          RELEASE_DB: begin
            if (!cand_pressed) begin
              if (db_cnt == DB_LAST) begin
                state     <= IDLE;
                key_vaild <= 1'b0;
                key_long  <= 1'b0;
                db_cnt    <= '0;
              end else begin
                db_cnt <= db_cnt + DB_ONE;
              end
            end else begin
              // Bounce back to held; hold_cnt resumes on the following tick.
              state  <= PRESSED;
              db_cnt <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_scan_encoder.sv
// Scoreboard bench for key_scan_encoder: a per-sample reference model queues
// expected output changes; a monitor pops them whenever the outputs change.
module tb_key_scan_encoder;

  localparam int CLK_DIV = 4;
  localparam int DB      = 3;
  localparam int LONG    = 10;
  localparam int NK      = 6;
  localparam logic [NK-1:0] REL = 6'h3F;

  logic          clk, reset;
  logic [NK-1:0] key_in;
  logic          key_vaild, key_press, key_long;
  logic [3:0]    key_code;

  key_scan_encoder #(
    .CLK_DIV(CLK_DIV), .DEBOUNCE_MS(DB), .LONG_MS(LONG), .NUM_KEYS(NK)
  ) dut (
    .clk(clk), .reset(reset), .key_in(key_in),
    .key_vaild(key_vaild), .key_code(key_code),
    .key_press(key_press), .key_long(key_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] c;
    logic       l;
    logic       p;
    int         t;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0, failures = 0;
  int  tick_num = 0;
  int  exp_press_cnt = 0, obs_press_cnt = 0;

  // Reference model: owner key, phase (0 none, 1 arming, 2 held, 3 releasing),
  // current run length of same-polarity samples and held-sample count.
  int         m_owner, m_phase, m_run, m_held;
  logic       m_v, m_l;
  logic [3:0] m_c;

  task automatic model_reset();
    m_owner = -1; m_phase = 0; m_run = 0; m_held = 0;
    m_v = 1'b0; m_l = 1'b0; m_c = 4'hF;
  endtask

  task automatic push_ev(input logic v, input logic [3:0] c, input logic l, input logic p);
    ev_t e;
    e.v = v; e.c = c; e.l = l; e.p = p; e.t = tick_num;
    exp_q.push_back(e);
  endtask

  task automatic model_step(input logic [NK-1:0] pat);
    logic [NK-1:0] down;
    logic old_v, old_l;
    bit   fired;
    down  = ~pat;
    old_v = m_v;
    old_l = m_l;
    fired = 0;
    case (m_phase)
      0: if (down != '0) begin
           for (int i = NK - 1; i >= 0; i--) if (down[i]) m_owner = i;
           m_run = 1; m_phase = 1;
         end
      1: if (down[m_owner]) begin
           m_run++;
           if (m_run == DB) begin
             m_phase = 2; m_v = 1'b1; m_c = 4'(m_owner); m_held = 0; fired = 1;
           end
         end else m_phase = 0;
      2: if (down[m_owner]) begin
           if (m_held < LONG) m_held++;
           if (m_held == LONG) m_l = 1'b1;
         end else begin
           m_run = 1; m_phase = 3;
         end
      default: if (!down[m_owner]) begin
           m_run++;
           if (m_run == DB) begin
             m_phase = 0; m_v = 1'b0; m_l = 1'b0;
           end
         end else m_phase = 2;
    endcase
    if (fired) begin
      push_ev(m_v, m_c, m_l, 1'b1);
      push_ev(m_v, m_c, m_l, 1'b0);
      exp_press_cnt++;
    end else if (m_v != old_v || m_l != old_l) begin
      push_ev(m_v, m_c, m_l, 1'b0);
    end
  endtask

  // One sample period: inputs settle, the next tick edge samples them.
  task automatic apply_tick(input logic [NK-1:0] pat);
    key_in = pat;
    repeat (CLK_DIV) @(posedge clk);
    tick_num++;
    model_step(pat);
    @(negedge clk);
  endtask

  task automatic hold(input logic [NK-1:0] pat, input int n);
    for (int i = 0; i < n; i++) apply_tick(pat);
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (key_vaild !== 1'b0 || key_code !== 4'hF || key_press !== 1'b0 || key_long !== 1'b0) begin
      failures++;
      $display("FAIL %s: actual v=%0b code=%0h press=%0b long=%0b required v=0 code=f press=0 long=0",
               name, key_vaild, key_code, key_press, key_long);
    end
  endtask

  // Monitor
  logic       prev_v, prev_l, prev_p;
  logic [3:0] prev_c;

  always @(negedge clk) begin
    if (reset) begin
      prev_v = 1'b0; prev_c = 4'hF; prev_l = 1'b0; prev_p = 1'b0;
    end else begin
      if (key_press === 1'b1) obs_press_cnt++;
      if (key_vaild !== prev_v || key_code !== prev_c || key_long !== prev_l || key_press !== prev_p) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change: actual v=%0b code=%0h long=%0b press=%0b at tick %0d required no change",
                   key_vaild, key_code, key_long, key_press, tick_num);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (key_vaild !== e.v || key_code !== e.c || key_long !== e.l || key_press !== e.p || tick_num != e.t) begin
            failures++;
            $display("FAIL output_event: actual v=%0b code=%0h long=%0b press=%0b tick=%0d required v=%0b code=%0h long=%0b press=%0b tick=%0d",
                     key_vaild, key_code, key_long, key_press, tick_num, e.v, e.c, e.l, e.p, e.t);
          end
        end
        prev_v = key_vaild; prev_c = key_code; prev_l = key_long; prev_p = key_press;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    key_in = REL;
    model_reset();
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset_state");
    @(negedge clk);
    reset = 1'b0;

    // Clean press of key 2
    hold(6'h3B, 8);  hold(REL, 5);
    // Press bounce on key 4
    hold(6'h2F, 2);  hold(REL, 1);  hold(6'h2F, 5);  hold(REL, 5);
    // Keys 1 and 3 together, then key 3 alone
    hold(6'h35, 5);  hold(6'h37, 8);  hold(REL, 5);
    // Long hold on key 0
    hold(6'h3E, 15); hold(REL, 5);
    // Release bounce on key 5
    hold(6'h1F, 5);  hold(REL, 1);  hold(6'h1F, 1);  hold(REL, 5);

    // Reset while key 2 is held and accepted
    hold(6'h3B, 6);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_before_reset: actual %0d pending required 0", exp_q.size());
    end
    reset = 1'b1;
    #1 check_reset_outputs("async_reset_mid_press");
    model_reset();
    key_in = REL;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_held");
    reset = 1'b0;
    hold(6'h3B, 8);  hold(REL, 5);

    // Randomised patterns
    begin
      logic [NK-1:0] pat;
      pat = REL;
      for (int i = 0; i < 220; i++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 5)      pat = pat;
        else if (r < 7) pat = REL;
        else if (r < 9) pat = ~(NK'(1) << $urandom_range(0, NK - 1));
        else            pat = NK'($urandom);
        apply_tick(pat);
      end
    end
    hold(REL, 8);
    repeat (4) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drained: actual %0d pending required 0", exp_q.size());
    end
    checks++;
    if (obs_press_cnt != exp_press_cnt) begin
      failures++;
      $display("FAIL press_count: actual %0d required %0d", obs_press_cnt, exp_press_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_scan_encoder.md
Name: key_scan_encoder

Overview:
- Producer side of the key_vaild/key_code interface that the per-key state block consumes.
- Synchronises six raw push-buttons and debounces them on an internal 1 kHz sampling tick.
- Encodes the single owning key into a 4-bit code with a held-valid flag, a one-cycle press pulse and a long-press flag.
- Sits between the board button pins and the key-state / clock-setting logic.

Parameters:
- CLK_DIV, 50000: clk cycles per sampling tick; 50 MHz gives a 1 kHz tick.
- DEBOUNCE_MS, 20: consecutive equal samples needed to accept a press or a release; must be at least 2.
- LONG_MS, 1000: samples a key must be held, counted from acceptance, before key_long asserts.
- NUM_KEYS, 6: number of button inputs; must be at most 15.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- key_in, input, NUM_KEYS: raw buttons, active-low (0 = pressed), asynchronous to clk.
- key_vaild, output, 1: high while a debounced key is owned.
- key_code, output, 4: index of the owned key, 0..NUM_KEYS-1; 4'hF after reset.
- key_press, output, 1: one-clk pulse when a press is accepted.
- key_long, output, 1: high once the owned key has been held LONG_MS samples.

Behaviour:
- Reset (async, active-high) forces:
  - key_vaild=0, key_press=0, key_long=0, key_code=4'hF.
  - FSM=IDLE, all counters=0, synchroniser flops=all-ones (released).
- Synchroniser: two flops per key on clk; pressed = ~key_in after the second stage.
- Tick generator:
  - Counter runs 0..CLK_DIV-1 and wraps.
  - tick is a one-clk pulse when counter==CLK_DIV-1.
  - All FSM decisions happen only on clk edges where tick=1; tick is an enable, never used as a clock.
- FSM states: IDLE, PRESS_DB, PRESSED, RELEASE_DB.
- IDLE, on tick:
  - If any key is pressed, cand = lowest pressed index, db_cnt=1, go to PRESS_DB.
  - Otherwise stay.
- PRESS_DB, on tick:
  - cand pressed and db_cnt==DEBOUNCE_MS-1: go to PRESSED, key_code=cand, key_vaild=1, key_press=1 for one clk, hold_cnt=0.
  - cand pressed otherwise: db_cnt+1.
  - cand released: go to IDLE, db_cnt=0.
  - Other keys are ignored.
- PRESSED, on tick:
  - cand pressed: hold_cnt+1, saturating at LONG_MS; key_long=1 when hold_cnt reaches LONG_MS.
  - cand released: db_cnt=1, go to RELEASE_DB.
- RELEASE_DB, on tick:
  - key_vaild and key_long stay unchanged.
  - cand released and db_cnt==DEBOUNCE_MS-1: go to IDLE, key_vaild=0, key_long=0; key_code holds its last value.
  - cand released otherwise: db_cnt+1.
  - cand pressed again (bounce): return to PRESSED, db_cnt=0; hold_cnt is kept and does not advance on that tick.
- Latency:
  - key_vaild rises one clk after the tick carrying the DEBOUNCE_MS-th consecutive pressed sample.
  - It falls one clk after the tick carrying the DEBOUNCE_MS-th consecutive released sample.
- Multiple keys:
  - Only the owning key is tracked from PRESS_DB until the return to IDLE.
  - Simultaneous presses in IDLE resolve to the lowest index.
  - A second key still held on return to IDLE starts a fresh PRESS_DB on the next tick.
- key_code is stable for the whole time key_vaild=1.
- key_press fires exactly once per accepted press; a bounce inside RELEASE_DB does not refire it.
- Reset mid-operation: immediate return to the reset values; no pulse is emitted.

Test Plan:
Bench settings for all scenarios: CLK_DIV=4, DEBOUNCE_MS=3, LONG_MS=10.
- Clean press of key 2 for 8 ticks, then release -> key_code=2; key_vaild rises one clk after the 3rd pressed tick; one key_press pulse; key_vaild falls one clk after the 3rd released tick; key_long stays 0.
- Press bounce on key 4 (pressed 2 ticks, released 1, pressed 5) -> no acceptance on the first burst; acceptance 3 ticks into the second burst; single key_press; key_code=4.
- Keys 1 and 3 pressed on the same tick -> key_code=1. Release key 1 while holding key 3 -> key_vaild drops, then reasserts with key_code=3 after 3 more ticks.
- Hold key 0 for 15 ticks -> key_long=1 from the 10th tick after acceptance; stays 1 until the release is debounced; clears together with key_vaild.
- Release bounce in RELEASE_DB (released 1 tick, pressed 1 tick) -> key_vaild stays 1 with no key_press pulse; a later clean 3-tick release clears it.
- Assert reset while in PRESSED -> outputs immediately 0/0/0/4'hF with no clk edge required; after release, normal operation resumes.
